// File: rtl/mux_pipe_nto1.sv
`default_nettype none
// ============================================================================
//  Module   : mux_pipe_nto1
//  Brief    : Two-stage registered N-to-1 word multiplexer with valid/stall/
//             flush tracking and out-of-range select detection.
//  Revision : 1.0  initial release
// ============================================================================
module mux_pipe_nto1 #(
   parameter int WIDTH  = 32,
   parameter int N      = 16,
   parameter int SEL_W  = $clog2(N),
   parameter int GROUPS = (N + 3) / 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [N*WIDTH-1:0]   din,
   input  logic [SEL_W-1:0]     sel,
   input  logic                 in_valid,
   input  logic                 stall,
   input  logic                 flush,
   output logic [WIDTH-1:0]     dout,
   output logic                 out_valid,
   output logic                 out_err
);

   // Upper select field is kept one bit wide when it would otherwise be empty.
   localparam int             c_UPW  = (SEL_W > 2) ? SEL_W - 2 : 1;
   localparam logic [SEL_W:0] c_NLIM = (SEL_W + 1)'(N);

   logic [WIDTH-1:0] w_words [GROUPS*4];
   logic [WIDTH-1:0] w_grp   [GROUPS];
   logic [1:0]       w_sel_lo;
   logic [c_UPW-1:0] w_sel_hi;
   logic             w_err;
   logic [WIDTH-1:0] w_s2;

   logic [WIDTH-1:0] r_s1_part [GROUPS];
   logic [c_UPW-1:0] r_s1_hi;
   logic             r_s1_valid;
   logic             r_s1_err;
   logic [WIDTH-1:0] r_dout;
   logic             r_out_valid;
   logic             r_out_err;

   generate
      for (genvar k = 0; k < GROUPS*4; k++) begin : g_word
         if (k < N) begin : g_real
            assign w_words[k] = din[k*WIDTH +: WIDTH];
         end else begin : g_pad
            assign w_words[k] = '0;
         end
      end

      if (SEL_W >= 2) begin : g_lo_full
         assign w_sel_lo = sel[1:0];
      end else begin : g_lo_short
         assign w_sel_lo = {1'b0, sel};
      end

      if (SEL_W > 2) begin : g_hi
         assign w_sel_hi = sel[SEL_W-1:2];
      end else begin : g_nohi
         assign w_sel_hi = '0;
      end

      for (genvar g = 0; g < GROUPS; g++) begin : g_grp
         assign w_grp[g] = w_sel_lo[1]
                         ? (w_sel_lo[0] ? w_words[4*g+3] : w_words[4*g+2])
                         : (w_sel_lo[0] ? w_words[4*g+1] : w_words[4*g]);
      end
   endgenerate

   assign w_err = ({1'b0, sel} >= c_NLIM);

   always_comb begin
      w_s2 = '0;
      for (int g = 0; g < GROUPS; g++) begin
         if (r_s1_hi == c_UPW'(g)) w_s2 = r_s1_part[g];
      end
   end

   // Data follows stall only; valid/err additionally obey flush, which wins.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int g = 0; g < GROUPS; g++) r_s1_part[g] <= '0;
         r_s1_hi     <= '0;
         r_s1_valid  <= 1'b0;
         r_s1_err    <= 1'b0;
         r_dout      <= '0;
         r_out_valid <= 1'b0;
         r_out_err   <= 1'b0;
      end else begin
         if (!stall) begin
            for (int g = 0; g < GROUPS; g++) r_s1_part[g] <= w_grp[g];
            r_s1_hi <= w_sel_hi;
            r_dout  <= r_s1_err ? '0 : w_s2;
         end
         if (flush) begin
            r_s1_valid  <= 1'b0;
            r_s1_err    <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_err   <= 1'b0;
         end else if (!stall) begin
            r_s1_valid  <= in_valid;
            r_s1_err    <= w_err;
            r_out_valid <= r_s1_valid;
            r_out_err   <= r_s1_err;
         end
      end
   end

   assign dout      = r_dout;
   assign out_valid = r_out_valid;
   assign out_err   = r_out_err;

endmodule
`default_nettype wire

// File: tb/tb_mux_pipe_nto1.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mux_pipe_nto1
//  Brief    : Bench for mux_pipe_nto1 in three configurations (16x32, 10x32, 2x8).
//  Revision : 1.0  initial release
// ============================================================================
module tb_mux_pipe_nto1;

   logic clk, rst, in_valid, stall, flush;

   logic [16*32-1:0] din16;
   logic [3:0]       sel16;
   logic [31:0]      dout16;
   logic             ov16, oe16;

   logic [10*32-1:0] din10;
   logic [3:0]       sel10;
   logic [31:0]      dout10;
   logic             ov10, oe10;

   logic [15:0]      din2;
   logic [0:0]       sel2;
   logic [7:0]       dout2;
   logic             ov2, oe2;

   int checks;
   int passes;

   // Expected contents of the two pipeline positions, per configuration.
   logic        m1v [3];
   logic        m1e [3];
   logic [31:0] m1d [3];
   logic        m2v [3];
   logic        m2e [3];
   logic [31:0] m2d [3];

   mux_pipe_nto1 #(.WIDTH(32), .N(16)) u16 (
      .clk(clk), .rst(rst), .din(din16), .sel(sel16), .in_valid(in_valid),
      .stall(stall), .flush(flush), .dout(dout16), .out_valid(ov16), .out_err(oe16));

   mux_pipe_nto1 #(.WIDTH(32), .N(10)) u10 (
      .clk(clk), .rst(rst), .din(din10), .sel(sel10), .in_valid(in_valid),
      .stall(stall), .flush(flush), .dout(dout10), .out_valid(ov10), .out_err(oe10));

   mux_pipe_nto1 #(.WIDTH(8), .N(2)) u2 (
      .clk(clk), .rst(rst), .din(din2), .sel(sel2), .in_valid(in_valid),
      .stall(stall), .flush(flush), .dout(dout2), .out_valid(ov2), .out_err(oe2));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input int d, input logic [31:0] obs,
                        input logic [31:0] exp);
      checks++;
      assert (obs === exp) passes++;
      else $error("FAIL %s cfg%0d observed=%h expected=%h", tag, d, obs, exp);
   endtask

   function automatic logic sel_err(input int d);
      case (d)
         0:       return int'(sel16) >= 16;
         1:       return int'(sel10) >= 10;
         default: return int'(sel2) >= 2;
      endcase
   endfunction

   function automatic logic [31:0] sel_word(input int d);
      case (d)
         0:       return din16[int'(sel16)*32 +: 32];
         1:       return din10[int'(sel10)*32 +: 32];
         default: return {24'h0, din2[int'(sel2)*8 +: 8]};
      endcase
   endfunction

   task automatic get_out(input int d, output logic v, output logic e,
                          output logic [31:0] o);
      case (d)
         0:       begin v = ov16; e = oe16; o = dout16; end
         1:       begin v = ov10; e = oe10; o = dout10; end
         default: begin v = ov2;  e = oe2;  o = {24'h0, dout2}; end
      endcase
   endtask

   task automatic model_clear();
      for (int d = 0; d < 3; d++) begin
         m1v[d] = 0; m1e[d] = 0; m1d[d] = '0;
         m2v[d] = 0; m2e[d] = 0; m2d[d] = '0;
      end
   endtask

   task automatic check_reset(input string tag);
      logic v, e;
      logic [31:0] o;
      for (int d = 0; d < 3; d++) begin
         get_out(d, v, e, o);
         check({tag, "_valid"}, d, {31'h0, v}, 32'h0);
         check({tag, "_err"},   d, {31'h0, e}, 32'h0);
         check({tag, "_dout"},  d, o,          32'h0);
      end
   endtask

   // One clock: advance the reference with the inputs seen at the edge, then compare.
   task automatic step();
      logic v, e;
      logic [31:0] o;
      logic        ne;
      @(posedge clk);
      for (int d = 0; d < 3; d++) begin
         ne = sel_err(d);
         if (!stall) begin
            m2v[d] = m1v[d]; m2e[d] = m1e[d]; m2d[d] = m1d[d];
            m1v[d] = in_valid; m1e[d] = ne; m1d[d] = ne ? 32'h0 : sel_word(d);
         end
         if (flush) begin
            m1v[d] = 0; m1e[d] = 0; m2v[d] = 0; m2e[d] = 0;
         end
      end
      #1;
      for (int d = 0; d < 3; d++) begin
         get_out(d, v, e, o);
         check("out_valid", d, {31'h0, v}, {31'h0, m2v[d]});
         if (m2v[d]) begin
            check("out_err", d, {31'h0, e}, {31'h0, m2e[d]});
            check("dout",    d, o,          m2d[d]);
         end
      end
   endtask

   // Called just after an edge: pulses rst for half a cycle between edges.
   task automatic pulse_reset();
      #2 rst = 1'b1;
      model_clear();
      #1 check_reset("rst_async");
      #4 rst = 1'b0;
   endtask

   task automatic set_req(input int s);
      logic [31:0] sv;
      sv       = s;
      sel16    = sv[3:0];
      sel10    = sv[3:0];
      sel2     = sv[0:0];
      in_valid = 1'b1;
   endtask

   initial begin
      checks = 0; passes = 0;
      model_clear();
      rst = 1'b1; in_valid = 0; stall = 0; flush = 0;
      sel16 = '0; sel10 = '0; sel2 = '0;
      for (int k = 0; k < 16; k++) din16[k*32 +: 32] = 32'hA000_0000 + k;
      for (int k = 0; k < 10; k++) din10[k*32 +: 32] = $urandom;
      din2 = {8'h5A, 8'hC3};

      @(posedge clk);
      #1 check_reset("rst_init");
      #2 rst = 1'b0;

      // Some traffic, then a mid-cycle reset before the sweep.
      for (int i = 0; i < 4; i++) begin set_req(i + 6); step(); end
      pulse_reset();

      // Sweep every select back-to-back (cfg1 sees 10..15 out of range).
      for (int s = 0; s < 16; s++) begin set_req(s); step(); end
      in_valid = 0;
      step(); step();

      // Stall for three cycles while sel=7 sits in the first stage.
      set_req(3);  step();
      set_req(7);  step();
      set_req(11); stall = 1;
      step(); step(); step();
      stall = 0;   step();
      in_valid = 0; step(); step();

      // Flush kills both in-flight requests.
      set_req(5); step();
      set_req(9); flush = 1; step();
      flush = 0; in_valid = 0; step(); step();

      // Same with stall and flush together.
      set_req(5); step();
      set_req(9); step();
      stall = 1; flush = 1; in_valid = 0; step();
      stall = 0; flush = 0; step(); step();

      // Randomised traffic.
      for (int i = 0; i < 300; i++) begin
         set_req($urandom_range(0, 15));
         in_valid = ($urandom_range(0, 3) != 0);
         stall    = ($urandom_range(0, 4) == 0);
         flush    = ($urandom_range(0, 9) == 0);
         if ($urandom_range(0, 7) == 0) din10[$urandom_range(0, 9)*32 +: 32] = $urandom;
         step();
      end
      stall = 0; flush = 0; in_valid = 0;
      step(); step();

      // Reset with two requests in flight; nothing stale may follow.
      set_req(1); step();
      set_req(2); step();
      in_valid = 0;
      pulse_reset();
      step(); step(); step();

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
`default_nettype wire
